uart_tx_framer: RTL and testbench

Parametrised, buffered UART transmitter. It is the next-generation replacement for the fixed 8N1 transmitter that carries Hamming-encoded nibbles off-chip. It accepts words over a valid/ready handshake into a small FIFO and serialises them LSB-first. Data width, bit period, parity and stop-bit count are configurable, and frames are sent back-to-back with no idle gap. It sits between the encoder/packet logic and the `uo_out[0]` TX pin.

---
 rtl/uart_tx_framer.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: buffered, parametrised UART transmitter.
// Words enter a power-of-two FIFO over valid/ready and leave LSB-first as
// start / data / optional parity / 1-2 stop bits, back-to-back with no idle gap.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// The producer holds in_valid and in_data stable until that edge. in_ready is
// a decode of the registered fifo_count only, never of in_valid.
module uart_tx_framer #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_BITS-1:0]            in_data,
    output logic                            tx,
    output logic                            tx_busy,
    output logic                            frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic [2:0]                      state_dbg
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = $clog2(DATA_BITS);

    localparam logic [BCNT_W-1:0] LAST_CLK  = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic [FCNT_W-1:0] DEPTH_C   = FCNT_W'(FIFO_DEPTH);
    localparam logic              ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;
    logic                 fifo_has;
    logic [DATA_BITS-1:0] head_word;
    logic                 head_par;

    assign in_ready  = (fifo_count < DEPTH_C);
    assign push      = in_valid && in_ready;
    assign fifo_has  = (fifo_count != '0);
    assign head_word = mem[rd_ptr];
    // Parity is settled when the word is popped, so the PARITY state just replays it.
    assign head_par  = (^head_word) ^ ODD_BIT;

    // Storage array: written on every accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t               state;
    logic [BCNT_W-1:0]    clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;

    state_t               nxt_state;
    logic [BCNT_W-1:0]    nxt_clk;
    logic [IDX_W-1:0]     nxt_idx;
    logic [DATA_BITS-1:0] nxt_shift;
    logic                 nxt_par;
    logic                 nxt_tx;

    assign state_dbg = state;

    // Next-state and next-line-value decode; popping happens on the same edge as entering START.
    always_comb begin
        nxt_state = state;
        nxt_clk   = clk_cnt;
        nxt_idx   = bit_idx;
        nxt_shift = shift_reg;
        nxt_par   = par_bit;
        nxt_tx    = tx;
        pop       = 1'b0;

        case (state)
            S_IDLE: begin
                nxt_tx = 1'b1;
                if (fifo_has) begin
                    pop       = 1'b1;
                    nxt_state = S_START;
                    nxt_clk   = '0;
                    nxt_idx   = '0;
                    nxt_shift = head_word;
                    nxt_par   = head_par;
                    nxt_tx    = 1'b0;
                end
            end

            default: begin
                if (clk_cnt != LAST_CLK) begin
                    nxt_clk = clk_cnt + 1'b1;
                end else begin
                    nxt_clk = '0;
                    case (state)
                        S_START: begin
                            nxt_state = S_DATA;
                            nxt_idx   = '0;
                            nxt_tx    = shift_reg[0];
                        end

                        S_DATA: begin
                            if (bit_idx == LAST_DATA) begin
                                nxt_idx = '0;
                                if (PARITY_EN != 0) begin
                                    nxt_state = S_PARITY;
                                    nxt_tx    = par_bit;
                                end else begin
                                    nxt_state = S_STOP;
                                    nxt_tx    = 1'b1;
                                end
                            end else begin
                                nxt_idx   = bit_idx + 1'b1;
                                nxt_shift = shift_reg >> 1;
                                nxt_tx    = shift_reg[1];
                            end
                        end

                        S_PARITY: begin
                            nxt_state = S_STOP;
                            nxt_idx   = '0;
                            nxt_tx    = 1'b1;
                        end

                        S_STOP: begin
                            if (bit_idx == LAST_STOP) begin
                                if (fifo_has) begin
                                    pop       = 1'b1;
                                    nxt_state = S_START;
                                    nxt_idx   = '0;
                                    nxt_shift = head_word;
                                    nxt_par   = head_par;
                                    nxt_tx    = 1'b0;
                                end else begin
                                    nxt_state = S_IDLE;
                                    nxt_tx    = 1'b1;
                                end
                            end else begin
                                nxt_idx = bit_idx + 1'b1;
                                nxt_tx  = 1'b1;
                            end
                        end

                        default: begin
                            nxt_state = S_IDLE;
                            nxt_tx    = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    // State register; tx, tx_busy and frame_done are registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            clk_cnt    <= nxt_clk;
            bit_idx    <= nxt_idx;
            shift_reg  <= nxt_shift;
            par_bit    <= nxt_par;
            tx         <= nxt_tx;
            tx_busy    <= (nxt_state != S_IDLE);
            frame_done <= (nxt_state == S_STOP) && (nxt_clk == LAST_CLK) &&
                          (nxt_idx == LAST_STOP);
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: three differently parametrised instances
// driven with directed and random words; a monitor compares every cycle of
// tx / tx_busy / frame_done / fifo_count / in_ready against a frame model.
module tb_uart_tx_framer;

  localparam int NI = 3;
  localparam int DB   [NI] = '{8, 5, 8};
  localparam int CPB  [NI] = '{4, 1, 2};
  localparam int DEP  [NI] = '{4, 2, 4};
  localparam int PEN  [NI] = '{0, 1, 1};
  localparam int PODD [NI] = '{0, 1, 0};
  localparam int SB   [NI] = '{1, 2, 2};

  typedef struct {
    int         inst;
    logic [8:0] data;
    int         push_cyc;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [NI-1:0] in_valid;
  logic [8:0]    in_data [NI];
  logic [NI-1:0] ready_w;
  logic [NI-1:0] tx_w;
  logic [NI-1:0] busy_w;
  logic [NI-1:0] done_w;
  logic [2:0]    cnt0;
  logic [1:0]    cnt1;
  logic [2:0]    cnt2;
  logic [2:0]    st0;
  logic [2:0]    st1;
  logic [2:0]    st2;

  uart_tx_framer #(.DATA_BITS(DB[0]), .CLKS_PER_BIT(CPB[0]), .FIFO_DEPTH(DEP[0]),
                   .PARITY_EN(PEN[0]), .PARITY_ODD(PODD[0]), .STOP_BITS(SB[0])) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ready_w[0]),
    .in_data(in_data[0][7:0]), .tx(tx_w[0]), .tx_busy(busy_w[0]),
    .frame_done(done_w[0]), .fifo_count(cnt0), .state_dbg(st0)
  );

  uart_tx_framer #(.DATA_BITS(DB[1]), .CLKS_PER_BIT(CPB[1]), .FIFO_DEPTH(DEP[1]),
                   .PARITY_EN(PEN[1]), .PARITY_ODD(PODD[1]), .STOP_BITS(SB[1])) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ready_w[1]),
    .in_data(in_data[1][4:0]), .tx(tx_w[1]), .tx_busy(busy_w[1]),
    .frame_done(done_w[1]), .fifo_count(cnt1), .state_dbg(st1)
  );

  uart_tx_framer #(.DATA_BITS(DB[2]), .CLKS_PER_BIT(CPB[2]), .FIFO_DEPTH(DEP[2]),
                   .PARITY_EN(PEN[2]), .PARITY_ODD(PODD[2]), .STOP_BITS(SB[2])) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ready_w[2]),
    .in_data(in_data[2][7:0]), .tx(tx_w[2]), .tx_busy(busy_w[2]),
    .frame_done(done_w[2]), .fifo_count(cnt2), .state_dbg(st2)
  );

  // ---------------- scoreboard state ----------------
  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         in_frame  [NI];
  bit         last      [NI];
  int         pos       [NI];
  int         fl        [NI];
  int         next_free [NI];
  logic [15:0] fb       [NI];

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc=%0d: got %0h expected %0h", name, i, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int i);
    n_checks++;
    n_fail++;
    $display("FAIL %s inst%0d cyc=%0d: bound expired", name, i, cyc);
  endtask

  function automatic int first_idx(input int i);
    foreach (exp_q[k]) if (exp_q[k].inst == i) return k;
    return -1;
  endfunction

  function automatic int pending(input int i);
    int n = 0;
    foreach (exp_q[k]) if (exp_q[k].inst == i) n++;
    return n;
  endfunction

  function automatic logic [8:0] msk(input int i, input logic [31:0] v);
    return 9'(v & ((32'd1 << DB[i]) - 1));
  endfunction

  // Frame as a list of bits: start 0, data LSB first, optional parity, stop 1s.
  function automatic logic [15:0] frame_of(input int i, input logic [8:0] d);
    logic [15:0] b = '1;
    int n = 0;
    logic p = (PODD[i] != 0);
    b[n] = 1'b0; n++;
    for (int k = 0; k < DB[i]; k++) begin
      b[n] = d[k];
      p = p ^ d[k];
      n++;
    end
    if (PEN[i] != 0) begin
      b[n] = p;
      n++;
    end
    for (int s = 0; s < SB[i]; s++) begin
      b[n] = 1'b1;
      n++;
    end
    return b;
  endfunction

  function automatic int frame_cycles(input int i);
    return (1 + DB[i] + PEN[i] + SB[i]) * CPB[i];
  endfunction

  function automatic int dut_cnt(input int i);
    if (i == 0) return int'(cnt0);
    if (i == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  // Record accepted pushes with the edge they happened on.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        if (in_valid[i] && ready_w[i]) begin
          exp_q.push_back('{inst: i, data: in_data[i], push_cyc: cyc});
        end
      end
    end
    cyc <= cyc + 1;
  end

  // Monitor: the frame for the oldest pending word starts at the later of
  // (push edge + 2) and the cycle after the previous frame.
  int   m_k;
  int   m_st;
  logic m_tx;
  logic m_busy;
  logic m_done;
  int   m_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < NI; i++) begin
        in_frame[i]  = 1'b0;
        last[i]      = 1'b0;
        pos[i]       = 0;
        next_free[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_k = first_idx(i);
        if (!in_frame[i] && m_k >= 0) begin
          m_st = exp_q[m_k].push_cyc + 2;
          if (next_free[i] > m_st) m_st = next_free[i];
          if (cyc == m_st) begin
            fb[i]       = frame_of(i, exp_q[m_k].data);
            fl[i]       = frame_cycles(i);
            pos[i]      = 0;
            in_frame[i] = 1'b1;
            exp_q.delete(m_k);
          end
        end
        if (in_frame[i]) begin
          m_tx   = fb[i][pos[i] / CPB[i]];
          m_busy = 1'b1;
          m_done = (pos[i] == fl[i] - 1);
        end else begin
          m_tx   = 1'b1;
          m_busy = 1'b0;
          m_done = 1'b0;
        end
        last[i] = in_frame[i] && (pos[i] == fl[i] - 1);
        m_cnt   = pending(i);
        chk("tx", i, 32'(tx_w[i]), 32'(m_tx));
        chk("tx_busy", i, 32'(busy_w[i]), 32'(m_busy));
        chk("frame_done", i, 32'(done_w[i]), 32'(m_done));
        chk("fifo_count", i, dut_cnt(i), m_cnt);
        chk("in_ready", i, 32'(ready_w[i]), 32'(m_cnt < DEP[i]));
        if (in_frame[i]) begin
          pos[i]++;
          if (pos[i] == fl[i]) begin
            in_frame[i]  = 1'b0;
            next_free[i] = cyc + 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int i, input logic [31:0] d);
    logic rdy;
    int   n = 0;
    in_data[i]  = msk(i, d);
    in_valid[i] = 1'b1;
    forever begin
      rdy = ready_w[i];
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 3000) begin
        fail_now("send_timeout", i);
        break;
      end
    end
    in_valid[i] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      #1;
      if (!in_frame[i] && pending(i) == 0) return;
    end
    fail_now("wait_idle", i);
  endtask

  task automatic rand_burst(input int i, input int words);
    for (int n = 0; n < words; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 60));
      send(i, $urandom);
    end
  endtask

  // Watchdog: stop the run if a phase never completes.
  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d: time limit reached", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    in_valid = '0;
    for (int i = 0; i < NI; i++) in_data[i] = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) begin
      chk("rst_tx", i, 32'(tx_w[i]), 1);
      chk("rst_busy", i, 32'(busy_w[i]), 0);
      chk("rst_done", i, 32'(done_w[i]), 0);
      chk("rst_ready", i, 32'(ready_w[i]), 1);
      chk("rst_count", i, dut_cnt(i), 0);
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(3);

    // Directed single frames: 0xA5 8N1, 0x1F 5-bit odd parity 2 stop, 0x07 even parity.
    fork
      send(0, 32'hA5);
      send(1, 32'h1F);
      send(2, 32'h07);
    join
    fork
      wait_idle(0);
      wait_idle(1);
      wait_idle(2);
    join

    // Continuous valid with 1..6 fills the FIFO and forces back-to-back frames.
    fork
      for (int w = 1; w <= 6; w++) send(0, w);
      for (int w = 1; w <= 6; w++) send(1, w);
      for (int w = 1; w <= 6; w++) send(2, w);
    join
    fork
      wait_idle(0);
      wait_idle(1);
      wait_idle(2);
    join

    // Random words with random gaps on all instances.
    fork
      rand_burst(0, 20);
      rand_burst(1, 30);
      rand_burst(2, 24);
    join
    fork
      wait_idle(0);
      wait_idle(1);
      wait_idle(2);
    join

    // Push on the exact edge a queued word pops at the end of STOP.
    send(0, 32'h3A);
    send(0, 32'hC6);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!last[0] && n < 500);
    if (!last[0]) fail_now("last_stop_wait", 0);
    send(0, 32'h5B);
    wait_idle(0);

    // Reset in the middle of a data bit with three words queued.
    for (int w = 0; w < 4; w++) send(0, $urandom_range(0, 255));
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(in_frame[0] && pos[0] >= 14) && n < 500);
    chk("queued_before_reset", 0, dut_cnt(0), 3);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("midrst_tx", i, 32'(tx_w[i]), 1);
      chk("midrst_busy", i, 32'(busy_w[i]), 0);
      chk("midrst_done", i, 32'(done_w[i]), 0);
      chk("midrst_count", i, dut_cnt(i), 0);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(60);
    send(0, 32'h3C);
    wait_idle(0);
    idle_cycles(5);

    chk("drained", 0, exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
